// File: rtl/quat_bitri_split_if.sv
// NCL link bundle for the quaternary splitter: one 1-of-4 input link and two
// downstream links (1-of-2 binary, 1-of-3 trinary), each with its completion.
interface quat_bitri_split_if;
  logic [3:0] quatin;
  logic       quatincomp;
  logic [1:0] binary;
  logic       binarycomp;
  logic [2:0] trinary;
  logic       trinarycomp;

  // master: the surrounding NCL environment (upstream source + downstream sinks)
  modport master (
    output quatin,
    input  quatincomp,
    input  binary,
    output binarycomp,
    input  trinary,
    output trinarycomp
  );

  // slave: the splitter itself
  modport slave (
    input  quatin,
    output quatincomp,
    output binary,
    input  binarycomp,
    output trinary,
    input  trinarycomp
  );
endinterface

// File: rtl/quat_bitri_split.sv
// Clocked NCL sink: splits a quaternary wavefront q into trinary t=min(q,2) and
// binary b=q-t, running the four-phase DATA/NULL handshake on all three links.
module quat_bitri_split #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               init,
    quat_bitri_split_if.slave  link,
    output logic [COUNT_W-1:0] tokens,
    output logic               err
);

    localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic {
        WAIT_DATA,
        HOLD_DATA
    } state_t;

    // Rail bundle per stage: {trinarycomp, binarycomp, quatin[3:0]}
    logic [NS-1:0][5:0] sync_q;
    logic [3:0]         sq;
    logic               sbc;
    logic               stc;
    logic               sq_multi;
    logic               sq_onehot;

    state_t             state_q, state_d;
    logic [1:0]         bin_q, bin_d;
    logic [2:0]         tri_q, tri_d;
    logic               comp_q, comp_d;
    logic [3:0]         cap_q, cap_d;
    logic [COUNT_W-1:0] tok_q, tok_d;
    logic               err_q, err_d;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NS-2:0], {link.trinarycomp, link.binarycomp, link.quatin}};
        end
    end

    assign sq        = sync_q[NS-1][3:0];
    assign sbc       = sync_q[NS-1][4];
    assign stc       = sync_q[NS-1][5];
    assign sq_multi  = |(sq & (sq - 4'd1));
    assign sq_onehot = (sq != 4'b0000) && !sq_multi;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= WAIT_DATA;
            bin_q   <= '0;
            tri_q   <= '0;
            comp_q  <= 1'b0;
            cap_q   <= '0;
            tok_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            tri_q   <= tri_d;
            comp_q  <= comp_d;
            cap_q   <= cap_d;
            tok_q   <= tok_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        tri_d   = tri_q;
        comp_d  = comp_q;
        cap_d   = cap_q;
        tok_d   = tok_q;
        err_d   = err_q;

        unique case (state_q)
            WAIT_DATA: begin
                // A clean wavefront waiting on downstream NULL acks is simply stalled.
                if (sq_onehot && !sbc && !stc) begin
                    state_d = HOLD_DATA;
                    comp_d  = 1'b1;
                    cap_d   = sq;
                    case (sq)
                        4'b0001: begin bin_d = 2'b01; tri_d = 3'b001; end
                        4'b0010: begin bin_d = 2'b01; tri_d = 3'b010; end
                        4'b0100: begin bin_d = 2'b01; tri_d = 3'b100; end
                        default: begin bin_d = 2'b10; tri_d = 3'b100; end
                    endcase
                end else if (sq_multi) begin
                    err_d = 1'b1;
                end
            end

            HOLD_DATA: begin
                if ((sq != 4'b0000) && (sq != cap_q)) begin
                    err_d = 1'b1;
                end
                if ((sq == 4'b0000) && sbc && stc) begin
                    state_d = WAIT_DATA;
                    bin_d   = '0;
                    tri_d   = '0;
                    comp_d  = 1'b0;
                    tok_d   = tok_q + COUNT_W'(1);
                end
            end

            default: state_d = WAIT_DATA;
        endcase
    end

    assign link.binary     = bin_q;
    assign link.trinary    = tri_q;
    assign link.quatincomp = comp_q;
    assign tokens          = tok_q;
    assign err             = err_q;

endmodule

// File: tb/tb_quat_bitri_split.sv
// Directed bench for quat_bitri_split: two instances (COUNT_W=8 and COUNT_W=2)
// share one stimulus so counter wrap is checked alongside the main behaviour.
module tb_quat_bitri_split;

    logic       clk;
    logic       init;
    logic [3:0] quatin_r;
    logic       bc_r;
    logic       tc_r;
    logic [7:0] tok8;
    logic [1:0] tok2;
    logic       err8;
    logic       err2;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_tok = 0;

    logic [1:0] EB [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    logic [2:0] ET [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    int unsigned ord [6][3] = '{'{0, 1, 2}, '{0, 2, 1}, '{1, 0, 2},
                                '{1, 2, 0}, '{2, 0, 1}, '{2, 1, 0}};

    quat_bitri_split_if if8 ();
    quat_bitri_split_if if2 ();

    assign if8.quatin      = quatin_r;
    assign if8.binarycomp  = bc_r;
    assign if8.trinarycomp = tc_r;
    assign if2.quatin      = quatin_r;
    assign if2.binarycomp  = bc_r;
    assign if2.trinarycomp = tc_r;

    quat_bitri_split #(.SYNC_STAGES(2), .COUNT_W(8)) dut8 (
        .clk    (clk),
        .init   (init),
        .link   (if8.slave),
        .tokens (tok8),
        .err    (err8)
    );

    quat_bitri_split #(.SYNC_STAGES(2), .COUNT_W(2)) dut2 (
        .clk    (clk),
        .init   (init),
        .link   (if2.slave),
        .tokens (tok2),
        .err    (err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] eb, input logic [2:0] et,
                             input logic ec);
        chk({tag, "/bin8"},  32'(if8.binary),     32'(eb));
        chk({tag, "/tri8"},  32'(if8.trinary),    32'(et));
        chk({tag, "/comp8"}, 32'(if8.quatincomp), 32'(ec));
        chk({tag, "/bin2"},  32'(if2.binary),     32'(eb));
        chk({tag, "/tri2"},  32'(if2.trinary),    32'(et));
        chk({tag, "/comp2"}, 32'(if2.quatincomp), 32'(ec));
    endtask

    task automatic check_tok(input string tag);
        chk({tag, "/tok8"}, 32'(tok8), 32'(exp_tok % 256));
        chk({tag, "/tok2"}, 32'(tok2), 32'(exp_tok % 4));
    endtask

    task automatic check_err(input string tag, input logic e);
        chk({tag, "/err8"}, 32'(err8), 32'(e));
        chk({tag, "/err2"}, 32'(err2), 32'(e));
    endtask

    task automatic edges(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present q with downstream comps already low: DATA appears on the 3rd edge.
    task automatic send(input int unsigned q, input string tag);
        @(negedge clk);
        quatin_r = 4'b0001 << q;
        edges(2);
        check_out({tag, "-early"}, 2'b00, 3'b000, 1'b0);
        edges(1);
        check_out(tag, EB[q], ET[q], 1'b1);
    endtask

    task automatic complete(input int unsigned q, input logic keep_tc, input string tag);
        @(negedge clk);
        quatin_r = 4'b0000;
        bc_r     = 1'b1;
        tc_r     = 1'b1;
        edges(2);
        check_out({tag, "-hold"}, EB[q], ET[q], 1'b1);
        edges(1);
        check_out({tag, "-null"}, 2'b00, 3'b000, 1'b0);
        exp_tok++;
        check_tok(tag);
        @(negedge clk);
        bc_r = 1'b0;
        if (!keep_tc) tc_r = 1'b0;
        edges(3);
    endtask

    task automatic apply_ev(input int unsigned idx);
        case (idx)
            0:       bc_r = 1'b1;
            1:       tc_r = 1'b1;
            default: quatin_r = 4'b0000;
        endcase
    endtask

    initial begin
        init     = 1'b1;
        quatin_r = 4'b0000;
        bc_r     = 1'b0;
        tc_r     = 1'b0;
        edges(3);
        check_out("reset", 2'b00, 3'b000, 1'b0);
        check_tok("reset");
        check_err("reset", 1'b0);
        @(negedge clk);
        init = 1'b0;
        edges(2);

        // Sweep q=0..3, then a fifth token wraps the 2-bit counter to 1.
        for (int unsigned q = 0; q < 4; q++) begin
            send(q, "sweep");
            complete(q, 1'b0, "sweep");
        end
        send(0, "wrap");
        complete(0, 1'b1, "wrap");

        // trinarycomp still high from the previous token: q=2 must stall.
        @(negedge clk);
        quatin_r = 4'b0100;
        edges(6);
        check_out("stall", 2'b00, 3'b000, 1'b0);
        @(negedge clk);
        tc_r = 1'b0;
        edges(2);
        check_out("stall-early", 2'b00, 3'b000, 1'b0);
        edges(1);
        check_out("stall-release", 2'b01, 3'b100, 1'b1);
        complete(2, 1'b0, "stall");

        // Completion ordering: all six orders of {binack, triack, input NULL}.
        for (int unsigned i = 0; i < 6; i++) begin
            send(i % 4, "order");
            for (int unsigned j = 0; j < 2; j++) begin
                @(negedge clk);
                apply_ev(ord[i][j]);
                edges(3);
            end
            check_out("order-partial", EB[i % 4], ET[i % 4], 1'b1);
            @(negedge clk);
            apply_ev(ord[i][2]);
            edges(2);
            check_out("order-hold", EB[i % 4], ET[i % 4], 1'b1);
            edges(1);
            check_out("order-null", 2'b00, 3'b000, 1'b0);
            exp_tok++;
            check_tok("order");
            @(negedge clk);
            bc_r = 1'b0;
            tc_r = 1'b0;
            edges(3);
        end
        send(3, "simul");
        complete(3, 1'b0, "simul");
        check_err("pre-illegal", 1'b0);

        // Two rails high in WAIT_DATA: flag error, capture nothing.
        @(negedge clk);
        quatin_r = 4'b0110;
        edges(3);
        check_err("illegal", 1'b1);
        check_out("illegal", 2'b00, 3'b000, 1'b0);
        @(negedge clk);
        quatin_r = 4'b0000;
        edges(3);
        send(2, "after-illegal");
        check_err("after-illegal", 1'b1);
        complete(2, 1'b0, "after-illegal");
        check_err("sticky", 1'b1);

        // Asynchronous reset in the middle of HOLD_DATA.
        send(3, "pre-reset");
        @(negedge clk);
        #2;
        init = 1'b1;
        #1;
        check_out("midreset", 2'b00, 3'b000, 1'b0);
        exp_tok = 0;
        check_tok("midreset");
        check_err("midreset", 1'b0);
        quatin_r = 4'b0000;
        edges(2);
        @(negedge clk);
        init = 1'b0;
        edges(2);
        send(1, "post-reset");
        complete(1, 1'b0, "post-reset");
        check_err("post-reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quat_bitri_split.md
Name: quat_bitri_split

Overview:
- Clocked sink for a 1-of-4 NCL quaternary link; inverse of the binary+trinary→quaternary adder.
- Accepts a quaternary DATA wavefront q (0..3) and splits it canonically into a trinary digit t = min(q,2) and a binary digit b = q − t.
- Emits b and t as 1-of-2 and 1-of-3 NCL wavefronts on two independent downstream links.
- Sits at the boundary where asynchronous NCL rails enter a single-clock domain; runs the four-phase DATA/NULL handshake on all three links.

Parameters:
SYNC_STAGES, 2, synchronizer flops per incoming rail and per incoming completion signal (min 2)
COUNT_W, 8, width of the completed-token counter

Ports:
clk  input  1  sole clock, rising edge
init  input  1  asynchronous active-high reset
quatin  input  4  1-of-4 NCL quaternary rails, asynchronous to clk; all-zero = NULL
quatincomp  output  1  completion to upstream: 0 = request DATA, 1 = DATA accepted / request NULL
binary  output  2  1-of-2 NCL binary digit rails, registered
binarycomp  input  1  downstream binary completion, asynchronous; 0 = request DATA, 1 = request NULL
trinary  output  3  1-of-3 NCL trinary digit rails, registered
trinarycomp  input  1  downstream trinary completion, asynchronous; same encoding
tokens  output  COUNT_W  count of fully completed wavefronts
err  output  1  sticky protocol-violation flag

Behaviour:
- The single clock clk and active-high asynchronous reset init are fixed.
- quatin[3:0], binarycomp and trinarycomp each pass through SYNC_STAGES flops. All decisions use synchronized values (sq, sbc, stc).
- Reset (init high, any time, including mid-handshake), all asynchronously:
  - quatincomp=0, binary=2'b00, trinary=3'b000, tokens=0, err=0.
  - Synchronizer flops clear; FSM enters WAIT_DATA.
- Decode table (q → binary rails, trinary rails):
  - 0 (quatin=0001) → 01, 001
  - 1 (0010) → 01, 010
  - 2 (0100) → 01, 100
  - 3 (1000) → 10, 100
- Rail encodings: binary[0] = b0, binary[1] = b1; trinary[k] = t==k.
- FSM state WAIT_DATA:
  - Outputs NULL, quatincomp=0.
  - If sq is one-hot AND sbc==0 AND stc==0: on the next edge, register the decoded rails and set quatincomp=1; go to HOLD_DATA.
  - If sq is one-hot but either downstream comp is still 1: stall in WAIT_DATA; the wavefront is held by the protocol, no error.
  - If sq has ≥2 rails high: set err=1, do not capture, stay in WAIT_DATA. Re-evaluate each cycle, so a later one-hot value is accepted.
- FSM state HOLD_DATA:
  - Outputs hold the DATA rails; quatincomp=1.
  - Any change of sq to a different non-NULL pattern sets err=1; captured data is unchanged.
  - When sq==0000 AND sbc==1 AND stc==1: on the next edge, outputs go NULL, quatincomp=0, tokens += 1 (wraps modulo 2^COUNT_W); go to WAIT_DATA.
  - Input NULL and downstream acks may arrive in any order or the same cycle; the transition occurs only once all three conditions hold.
- Latency:
  - Input rail rising → output DATA and quatincomp rising: SYNC_STAGES+1 clk edges, given downstream comps already synchronized low.
  - Last of {input NULL, both acks} → outputs NULL: SYNC_STAGES+1 edges.
- Outputs change only on clk edges (besides init), are never multi-hot, and never present DATA while quatincomp=0.
- err clears only by init.
- Throughput: at most one wavefront per 2·(SYNC_STAGES+1) cycles plus environment delay.

Test Plan:
- Reset mid-HOLD_DATA with q=3: assert init → immediately binary=00, trinary=000, quatincomp=0, tokens=0. After release, a new q=1 is accepted normally.
- Sweep q=0,1,2,3 with immediate downstream ack → binary/trinary = 01/001, 01/010, 01/100, 10/100. Output appears 3 edges after quatin rises (SYNC_STAGES=2); tokens=4 at end.
- Downstream stall: hold trinarycomp=1 from the previous token, present q=2 → no capture, quatincomp stays 0. Drop trinarycomp → capture 3 edges later.
- Order independence: in HOLD_DATA, raise binarycomp, then trinarycomp, then return quatin to NULL, in all 6 orders plus simultaneous → NULL outputs exactly 3 edges after the last event, tokens +1 each.
- Illegal input: quatin=0110 in WAIT_DATA → err=1, outputs stay NULL. Then quatin=0000 → 0100 → accepted as q=2, err remains 1.
- Counter wrap: COUNT_W=2, five completed tokens → tokens = 0,1,2,3,0,1 sequence ending at 1.
